// File: rtl/ysyx_22050854_multiplier_booth.sv
// ----------------------------------------------------------------------------
// ysyx_22050854_multiplier_booth
//
// Radix-4 Booth iterative multiplier for the NPC execute stage. It covers
// mul/mulh/mulhsu/mulhu (full XLEN x XLEN) and mulw (32 x 32 signed, result
// sign-extended from bit 31). It retires two multiplier bits per cycle and
// holds its result until the consumer takes it.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   mul_valid       request valid (accepted when mul_valid & mul_ready & ~flush)
//   flush           cancel any request, in flight or completed
//   mulw            32-bit signed multiply with sign-extended result
//   mul_signed      [1] multiplicand signed, [0] multiplier signed (ignored for mulw)
//   multiplicand    operand A (XLEN)
//   multiplier      operand B (XLEN)
//   out_ready       consumer accepts the result
//   mul_ready       high in IDLE
//   mul_doing       high in BUSY
//   out_valid       result valid, held until out_ready
//   result_hi       product[2*XLEN-1:XLEN] (0 for mulw)
//   result_lo       product[XLEN-1:0] (sext(product[31:0]) for mulw)
//
// Optional feature: define YSYX_22050854_MUL_EARLY_OUT_EN to let the FSM
// finish as soon as the remaining multiplier bits can only recode to zero.
// ----------------------------------------------------------------------------
module ysyx_22050854_multiplier_booth #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mul_valid,
  input  logic            flush,
  input  logic            mulw,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  input  logic            out_ready,
  output logic            mul_ready,
  output logic            mul_doing,
  output logic            out_valid,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  localparam int AW    = 2 * XLEN + 4;   // accumulator / shifted multiplicand
  localparam int BW    = XLEN + 3;       // extended multiplier plus Booth LSB
  localparam int CNT_W = $clog2(XLEN + 2);

  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'((XLEN + 2) / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_W    = CNT_W'(16);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     a_q, a_d;
  logic [BW-1:0]     b_q, b_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mulw_q, mulw_d;
  logic [XLEN-1:0]   res_hi_q, res_hi_d;
  logic [XLEN-1:0]   res_lo_q, res_lo_d;

  logic [XLEN+1:0]   opa_ext, opb_ext;
  logic [AW-1:0]     acc_nxt;
  logic [BW-1:0]     b_shr;
  logic              last_iter;
  logic              early;

  // Booth radix-4 partial product selection: {b[i+1], b[i], b[i-1]} -> {0, +-A, +-2A}.
  function automatic logic [AW-1:0] booth_pp(input logic [2:0] grp, input logic [AW-1:0] a);
    logic [AW-1:0] a2;
    a2 = {a[AW-2:0], 1'b0};
    case (grp)
      3'b001, 3'b010: return a;
      3'b011:         return a2;
      3'b100:         return ~a2 + AW'(1);
      3'b101, 3'b110: return ~a + AW'(1);
      default:        return '0;
    endcase
  endfunction

  always_comb begin
    // Operand extension to XLEN+2 bits; mulw forces signed 32-bit sources.
    if (mulw) begin
      opa_ext = {{(XLEN-30){multiplicand[31]}}, multiplicand[31:0]};
      opb_ext = {{(XLEN-30){multiplier[31]}}, multiplier[31:0]};
    end else begin
      opa_ext = {{2{mul_signed[1] & multiplicand[XLEN-1]}}, multiplicand};
      opb_ext = {{2{mul_signed[0] & multiplier[XLEN-1]}}, multiplier};
    end

    acc_nxt   = acc_q + booth_pp(b_q[2:0], a_q);
    b_shr     = {{2{b_q[BW-1]}}, b_q[BW-1:2]};
    last_iter = mulw_q ? (cnt_q == LAST_W) : (cnt_q == LAST_FULL);
`ifdef YSYX_22050854_MUL_EARLY_OUT_EN
    // Remaining groups all recode to 0 once the shifted register is uniform.
    early     = (b_shr == '0) || (&b_shr);
`else
    early     = 1'b0;
`endif

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mulw_d   = mulw_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;

    case (state_q)
      S_IDLE: begin
        if (mul_valid && !flush) begin
          a_d     = {{(XLEN+2){opa_ext[XLEN+1]}}, opa_ext};
          b_d     = {opb_ext, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          mulw_d  = mulw;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_nxt;
          b_d   = b_shr;
          a_d   = {a_q[AW-3:0], 2'b00};
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter || early) begin
            state_d = S_DONE;
            if (mulw_q) begin
              res_hi_d = '0;
              res_lo_d = {{(XLEN-32){acc_nxt[31]}}, acc_nxt[31:0]};
            end else begin
              res_hi_d = acc_nxt[2*XLEN-1:XLEN];
              res_lo_d = acc_nxt[XLEN-1:0];
            end
          end
        end
      end
      S_DONE: begin
        // flush and out_ready lead to the same place; results read 0 once invalid.
        if (flush || out_ready) begin
          state_d  = S_IDLE;
          res_hi_d = '0;
          res_lo_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mulw_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mulw_q   <= mulw_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  assign mul_ready = (state_q == S_IDLE);
  assign mul_doing = (state_q == S_BUSY);
  assign out_valid = (state_q == S_DONE);
  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;

endmodule
